// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-cycle FREEZE/REDIRECT/BUBBLE/RUN decision, load/flush enables,
// saturating performance counters and a sticky memory-hang flag.
module hazard_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1_addr,
    input  logic [4:0]       ifid_rs2_addr,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic             ex_redirect,
    input  logic             cnt_clr,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] redirect_count,
    output logic             mem_timeout
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FREEZE   = 2'd1;
    localparam logic [1:0] ST_BUBBLE   = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             freeze;
    logic             load_use;
    logic [1:0]       state;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] redir_q, redir_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        freeze   = !imem_resp || (dmem_req && !dmem_resp);
        load_use = idex_mem_read && (idex_rd != 5'd0) &&
                   ((ifid_uses_rs1 && (ifid_rs1_addr == idex_rd)) ||
                    (ifid_uses_rs2 && (ifid_rs2_addr == idex_rd)));
        // A redirect outranks a load-use stall: the dependent instruction is squashed anyway.
        if (freeze)           state = ST_FREEZE;
        else if (ex_redirect) state = ST_REDIRECT;
        else if (load_use)    state = ST_BUBBLE;
        else                  state = ST_RUN;
    end

    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        hz_state    = ST_RUN;
        if (!rst) begin
            hz_state = state;
            case (state)
                ST_RUN: begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end
                ST_BUBBLE: begin
                    load_id_ex  = 1'b1;
                    flush_id_ex = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                end
                ST_REDIRECT: begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Counters saturate at all-ones; clear wins over any increment in the same cycle.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        redir_d  = redir_q;
        if (cnt_clr) begin
            stall_d  = '0;
            bubble_d = '0;
            redir_d  = '0;
        end else begin
            if ((state == ST_FREEZE || state == ST_BUBBLE) && !(&stall_q))
                stall_d = stall_q + CNT_ONE;
            if (state == ST_BUBBLE && !(&bubble_q))
                bubble_d = bubble_q + CNT_ONE;
            if (state == ST_REDIRECT && !(&redir_q))
                redir_d = redir_q + CNT_ONE;
        end
    end

    always_comb begin
        run_d = '0;
        if (freeze)
            run_d = (run_q >= RUN_LIMIT) ? run_q : run_q + RUN_ONE;
        timeout_d = timeout_q || (run_d >= RUN_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q   <= '0;
            bubble_q  <= '0;
            redir_q   <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
            redir_q   <= redir_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cycles   = stall_q;
    assign bubble_count   = bubble_q;
    assign redirect_count = redir_q;
    assign mem_timeout    = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with TIMEOUT=4, CNT_W=4 against a behavioural model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int MAXC    = 15;

    logic clk = 1'b0;
    logic rst, imem_resp, dmem_req, dmem_resp, idex_mem_read, ifid_uses_rs1, ifid_uses_rs2;
    logic ex_redirect, cnt_clr;
    logic [4:0] idex_rd, ifid_rs1_addr, ifid_rs2_addr;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex;
    logic [1:0] hz_state;
    logic [CNT_W-1:0] stall_cycles, bubble_count, redirect_count;
    logic mem_timeout;

    int checks = 0;
    int errors = 0;

    int m_stall = 0, m_bub = 0, m_redir = 0, m_run = 0;
    bit m_to = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1_addr(ifid_rs1_addr),
        .ifid_rs2_addr(ifid_rs2_addr), .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .ex_redirect(ex_redirect), .cnt_clr(cnt_clr), .load_pc(load_pc), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .hz_state(hz_state),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .redirect_count(redirect_count),
        .mem_timeout(mem_timeout)
    );

    wire [6:0] ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};

    // Reference decision: 0 RUN, 1 FREEZE, 2 BUBBLE, 3 REDIRECT.
    function automatic int exp_state();
        bit hazard;
        if (rst) return 0;
        if (!imem_resp || (dmem_req && !dmem_resp)) return 1;
        if (ex_redirect) return 3;
        hazard = idex_mem_read && idex_rd != 0 &&
                 ((ifid_uses_rs1 && ifid_rs1_addr == idex_rd) || (ifid_uses_rs2 && ifid_rs2_addr == idex_rd));
        return hazard ? 2 : 0;
    endfunction

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    function automatic logic [6:0] exp_ctl();
        if (rst) return 7'b0000000;
        case (exp_state())
            0:       return 7'b1111100;
            1:       return 7'b0000000;
            2:       return 7'b0011101;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic set_in(input bit im, input bit dq, input bit dr, input bit mr, input int rd,
                          input int r1, input int r2, input bit u1, input bit u2, input bit redir);
        imem_resp = im; dmem_req = dq; dmem_resp = dr; idex_mem_read = mr;
        idex_rd = 5'(rd); ifid_rs1_addr = 5'(r1); ifid_rs2_addr = 5'(r2);
        ifid_uses_rs1 = u1; ifid_uses_rs2 = u2; ex_redirect = redir;
        #1;
    endtask

    // Advance one clock edge and update the model from the inputs held during that cycle.
    task automatic tick();
        int s;
        s = exp_state();
        @(posedge clk);
        if (rst) begin
            m_stall = 0; m_bub = 0; m_redir = 0; m_run = 0; m_to = 0;
        end else begin
            if (cnt_clr) begin
                m_stall = 0; m_bub = 0; m_redir = 0;
            end else begin
                if ((s == 1 || s == 2) && m_stall < MAXC) m_stall++;
                if (s == 2 && m_bub < MAXC) m_bub++;
                if (s == 3 && m_redir < MAXC) m_redir++;
            end
            m_run = (s == 1) ? m_run + 1 : 0;
            if (m_run >= TIMEOUT) m_to = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; cnt_clr = 0;
        set_in(1, 0, 0, 1, 5, 5, 5, 1, 1, 1);
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000000", ctl); end
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", hz_state); end
        tick();
        checks++;
        if ({stall_cycles, bubble_count, redirect_count} !== '0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_cnt: got %0d %0d %0d to=%b expected 0 0 0 to=0",
                               stall_cycles, bubble_count, redirect_count, mem_timeout);
        end
        rst = 0;
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 1, 5, 1, 5, 0, 1, 0);
        checks++;
        if (hz_state !== 2'd2 || ctl !== 7'b0011101) begin
            errors++; $display("FAIL load_use: got state=%0d ctl=%b expected state=2 ctl=0011101", hz_state, ctl);
        end
        tick();
        checks++;
        if (bubble_count !== 4'd1 || stall_cycles !== 4'd1) begin
            errors++; $display("FAIL load_use_cnt: got bub=%0d stall=%0d expected 1 1", bubble_count, stall_cycles);
        end
    endtask

    task automatic test_no_hazard();
        set_in(1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        checks++;
        if (hz_state !== 2'd0 || ctl !== 7'b1111100) begin
            errors++; $display("FAIL rd_zero: got state=%0d ctl=%b expected state=0 ctl=1111100", hz_state, ctl);
        end
        tick();
        set_in(1, 0, 0, 1, 5, 1, 5, 0, 0, 0);
        checks++;
        if (hz_state !== 2'd0 || ctl !== 7'b1111100) begin
            errors++; $display("FAIL no_use_rs2: got state=%0d ctl=%b expected state=0 ctl=1111100", hz_state, ctl);
        end
        tick();
    endtask

    task automatic test_freeze_redirect();
        cnt_clr = 1; set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); cnt_clr = 0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (hz_state !== 2'd1 || ctl !== 7'b0) begin
                errors++; $display("FAIL freeze_%0d: got state=%0d ctl=%b expected state=1 ctl=0000000", i, hz_state, ctl);
            end
            tick();
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (hz_state !== 2'd3 || ctl !== 7'b1111111) begin
            errors++; $display("FAIL redirect_after_freeze: got state=%0d ctl=%b expected state=3 ctl=1111111", hz_state, ctl);
        end
        tick();
        checks++;
        if (stall_cycles !== 4'd3 || redirect_count !== 4'd1) begin
            errors++; $display("FAIL freeze_cnt: got stall=%0d redir=%0d expected 3 1", stall_cycles, redirect_count);
        end
    endtask

    task automatic test_redirect_hazard();
        set_in(1, 0, 0, 1, 7, 7, 3, 1, 1, 1);
        checks++;
        if (hz_state !== 2'd3 || ctl !== 7'b1111111) begin
            errors++; $display("FAIL redir_hazard: got state=%0d ctl=%b expected state=3 ctl=1111111", hz_state, ctl);
        end
        tick();
        checks++;
        if (bubble_count !== 4'd0 || redirect_count !== 4'd2) begin
            errors++; $display("FAIL redir_hazard_cnt: got bub=%0d redir=%0d expected 0 2", bubble_count, redirect_count);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (mem_timeout !== (i >= 4)) begin
                errors++; $display("FAIL timeout_edge_%0d: got %b expected %b", i, mem_timeout, i >= 4);
            end
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        cnt_clr = 1; tick(); cnt_clr = 0;
        checks++;
        if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", mem_timeout); end
        rst = 1; tick(); rst = 0;
        checks++;
        if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_rst: got %b expected 0", mem_timeout); end
    endtask

    task automatic test_saturate();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_sat: got %0d expected 15", stall_cycles); end
        cnt_clr = 1; tick(); cnt_clr = 0;
        checks++;
        if (stall_cycles !== 4'd0) begin errors++; $display("FAIL clr_vs_freeze: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_rst_mid();
        set_in(1, 0, 0, 1, 9, 9, 0, 1, 0, 0); tick();
        rst = 1; set_in(0, 0, 0, 1, 9, 9, 0, 1, 0, 0);
        checks++;
        if (ctl !== 7'b0 || hz_state !== 2'd0) begin
            errors++; $display("FAIL rst_mid: got state=%0d ctl=%b expected state=0 ctl=0000000", hz_state, ctl);
        end
        tick(); rst = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ctl !== 7'b1111100 || hz_state !== 2'd0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_fresh: got state=%0d ctl=%b to=%b expected state=0 ctl=1111100 to=0",
                               hz_state, ctl, mem_timeout);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cnt_clr = ($urandom_range(15) == 0);
            set_in($urandom_range(7) != 0, $urandom_range(1), $urandom_range(3) != 0, $urandom_range(1),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(1),
                   $urandom_range(1), $urandom_range(3) == 0);
            checks++;
            if (int'(hz_state) != exp_state() || ctl !== exp_ctl()) begin
                errors++; $display("FAIL rand_ctl_%0d: got state=%0d ctl=%b expected state=%0d ctl=%b",
                                   i, hz_state, ctl, exp_state(), exp_ctl());
            end
            tick();
            checks++;
            if (int'(stall_cycles) != m_stall || int'(bubble_count) != m_bub ||
                int'(redirect_count) != m_redir || mem_timeout !== m_to) begin
                errors++; $display("FAIL rand_cnt_%0d: got %0d %0d %0d to=%b expected %0d %0d %0d to=%b", i,
                                   stall_cycles, bubble_count, redirect_count, mem_timeout,
                                   m_stall, m_bub, m_redir, m_to);
            end
        end
    endtask

    initial begin
        rst = 1; cnt_clr = 0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_freeze_redirect();
        test_redirect_hazard();
        test_timeout();
        test_saturate();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
